// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and combinational register loads.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [2:0]  sel,
   input  logic        wen,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        hit,
   output logic        tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic PAR_EN = 1'b1;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   localparam logic PAR_EN = 1'b0;
`endif

   logic          aligned, wr_en, wr_txdata, wr_status, wr_baud;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full, empty, push_ok, pop, ovf_q, busy;
   logic [15:0]   baud_q;
   logic [7:0]    head;

   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [15:0]   div_q, div_d, cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          tx_q, tx_d, start_frame;
`ifdef UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   logic [31:0]   reg_val, fmt_val;

   assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
   assign aligned   = (addr[1:0] == 2'b00);
   assign wr_en     = wen & hit & aligned;
   assign wr_txdata = wr_en & (addr[3:2] == 2'd0);
   assign wr_status = wr_en & (addr[3:2] == 2'd1);
   assign wr_baud   = wr_en & (addr[3:2] == 2'd2);

   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
   assign push_ok = wr_txdata & (~full | pop);
   assign head    = mem_q[rd_ptr_q];
   assign busy    = (state_q != S_IDLE);
   assign tx      = tx_q;

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         baud_q   <= DEFAULT_DIV;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (wr_txdata & full & ~pop)      ovf_q <= 1'b1;
         else if (wr_status & data_i[3])   ovf_q <= 1'b0;
         if (wr_baud) begin
            if (sel[1:0] == 2'b00) baud_q[7:0] <= data_i[7:0];
            else                   baud_q      <= data_i[15:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         bit_q    <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      tx_d        = tx_q;
      pop         = 1'b0;
      start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!empty) start_frame = 1'b1;
         end
         S_START: begin
            if (cnt_q == '0) begin
               tx_d    = shift_q[0];
               cnt_d   = div_q;
               bit_d   = '0;
               state_d = S_DATA;
            end else cnt_d = cnt_q - 16'd1;
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = div_q;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else cnt_d = cnt_q - 16'd1;
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == '0) begin
               tx_d    = 1'b1;
               cnt_d   = div_q;
               state_d = S_STOP;
            end else cnt_d = cnt_q - 16'd1;
         end
`endif
         S_STOP: begin
            if (cnt_q == '0) begin
               if (!empty) start_frame = 1'b1;
               else begin
                  tx_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end else cnt_d = cnt_q - 16'd1;
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
      // Divisor is latched per frame so BAUDDIV writes never disturb a frame in flight.
      if (start_frame) begin
         pop     = 1'b1;
         shift_d = head;
         div_d   = baud_q;
         cnt_d   = baud_q;
         tx_d    = 1'b0;
         state_d = S_START;
`ifdef UART_TX_PARITY_EN
         parity_d = ^head;
`endif
      end
   end

   always_comb begin
      reg_val = '0;
      case (addr[3:2])
         2'd1:    reg_val = {16'b0, 8'(count_q), 3'b0, PAR_EN, ovf_q, busy, empty, full};
         2'd2:    reg_val = {16'b0, baud_q};
         default: reg_val = '0;
      endcase
      case (sel)
         3'b000:  fmt_val = {{24{reg_val[7]}}, reg_val[7:0]};
         3'b001:  fmt_val = {{16{reg_val[15]}}, reg_val[15:0]};
         3'b100:  fmt_val = {24'b0, reg_val[7:0]};
         3'b101:  fmt_val = {16'b0, reg_val[15:0]};
         default: fmt_val = reg_val;
      endcase
      data_o = (hit & aligned) ? fmt_val : 32'b0;
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, serial timing, FIFO overflow and reset abort.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef UART_TX_PARITY_EN
   localparam int          NB   = 11;
   localparam logic [31:0] PBIT = 32'h10;
`else
   localparam int          NB   = 10;
   localparam logic [31:0] PBIT = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = '0;
   logic [2:0]  sel = '0;
   logic        wen = 1'b0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        hit;
   logic        tx;

   int checks_cnt = 0;
   int errors_cnt = 0;

   uart_tx_mmio dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .sel    (sel),
      .wen    (wen),
      .data_i (data_i),
      .data_o (data_o),
      .hit    (hit),
      .tx     (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      @(negedge clk);
      addr = a; sel = s; data_i = d; wen = 1'b1;
      @(posedge clk);
      #1 wen = 1'b0;
      $display("ST addr=%08h sel=%0d data=%08h", a, s, d);
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] s, output logic [31:0] d);
      @(negedge clk);
      addr = a; sel = s; wen = 1'b0;
      #1 d = data_o;
      $display("LD addr=%08h sel=%0d data=%08h", a, s, d);
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (NB == 11 && i == 9) return ^b;
      return 1'b1;
   endfunction

   logic [31:0] rd;
   logic [7:0]  bytes4 [3];
   logic        saw_low;

   initial begin
      bytes4[0] = 8'hA5; bytes4[1] = 8'h3C; bytes4[2] = 8'h07;

      // Reset state
      repeat (3) @(negedge clk);
      check("tx_in_reset", {31'b0, tx}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      addr = BASE + 32'h4; #1;
      check("hit_status", {31'b0, hit}, 32'h1);
      load(BASE + 32'h4, 3'b010, rd); check("rst_status", rd, 32'h2 | PBIT);
      load(BASE + 32'h8, 3'b010, rd); check("rst_bauddiv", rd, 32'h363);
      check("rst_tx", {31'b0, tx}, 32'h1);

      // Load formatting and decode
      store(BASE + 32'h8, 3'b010, 32'hFFFF_8001);
      load(BASE + 32'h8, 3'b010, rd); check("lw_baud", rd, 32'h0000_8001);
      load(BASE + 32'h8, 3'b001, rd); check("lh_baud", rd, 32'hFFFF_8001);
      load(BASE + 32'h8, 3'b101, rd); check("lhu_baud", rd, 32'h0000_8001);
      store(BASE + 32'h8, 3'b000, 32'hFFFF_FF80);
      load(BASE + 32'h8, 3'b010, rd); check("sb_baud_low", rd, 32'h0000_8080);
      store(BASE + 32'h8, 3'b010, 32'h0000_0080);
      load(BASE + 32'h8, 3'b000, rd); check("lb_baud", rd, 32'hFFFF_FF80);
      load(BASE + 32'h8, 3'b100, rd); check("lbu_baud", rd, 32'h0000_0080);
      load(BASE + 32'h0, 3'b010, rd); check("rd_txdata", rd, 32'h0);
      load(BASE + 32'hC, 3'b010, rd); check("rd_reserved", rd, 32'h0);
      load(BASE + 32'h5, 3'b010, rd); check("rd_misaligned", rd, 32'h0);
      @(negedge clk);
      addr = BASE + 32'h10; sel = 3'b010; #1;
      check("miss_hit", {31'b0, hit}, 32'h0);
      check("miss_data", data_o, 32'h0);
      store(BASE + 32'h10, 3'b010, 32'h55);
      store(BASE + 32'h18, 3'b010, 32'h3);
      store(BASE + 32'h9,  3'b010, 32'h5);
      load(BASE + 32'h8, 3'b010, rd); check("baud_unchanged", rd, 32'h80);
      load(BASE + 32'h4, 3'b010, rd); check("status_unchanged", rd, 32'h2 | PBIT);
      check("tx_unchanged", {31'b0, tx}, 32'h1);

      // Single frame, 4 clocks per bit
      store(BASE + 32'h8, 3'b010, 32'd3);
      store(BASE + 32'h0, 3'b000, 32'h55);
      @(negedge clk);
      check("f55_pre", {31'b0, tx}, 32'h1);
      for (int k = 0; k < NB * 4; k++) begin
         @(negedge clk);
         check($sformatf("f55_tx_%0d", k), {31'b0, tx}, {31'b0, frame_bit(8'h55, k / 4)});
         check($sformatf("f55_busy_%0d", k), {31'b0, dut.busy}, 32'h1);
      end
      @(negedge clk);
      check("f55_busy_end", {31'b0, dut.busy}, 32'h0);
      check("f55_tx_end", {31'b0, tx}, 32'h1);

      // Back-to-back frames with no idle gap
      for (int j = 0; j < 3; j++) store(BASE + 32'h0, 3'b000, {24'b0, bytes4[j]});
      for (int k = 1; k < 3 * NB * 4; k++) begin
         @(negedge clk);
         check($sformatf("b2b_tx_%0d", k), {31'b0, tx},
               {31'b0, frame_bit(bytes4[k / (NB * 4)], (k % (NB * 4)) / 4)});
      end
      @(negedge clk);
      check("b2b_busy_end", {31'b0, dut.busy}, 32'h0);
      load(BASE + 32'h4, 3'b010, rd); check("b2b_status", rd, 32'h2 | PBIT);

      // Overflow with a slow divisor
      store(BASE + 32'h8, 3'b010, 32'd100);
      for (int j = 0; j < 10; j++) store(BASE + 32'h0, 3'b000, 32'(j * 17));
      load(BASE + 32'h4, 3'b010, rd); check("ovf_status", rd, 32'h0000_080D | PBIT);
      store(BASE + 32'h4, 3'b010, 32'h8);
      load(BASE + 32'h4, 3'b010, rd); check("ovf_cleared", rd, 32'h0000_0805 | PBIT);

      // Asynchronous reset in the middle of the data bits of byte 0x00
      repeat (150) @(negedge clk);
      check("pre_rst_tx", {31'b0, tx}, 32'h0);
      check("pre_rst_busy", {31'b0, dut.busy}, 32'h1);
      #2 rst = 1'b0;
      #1 check("rst_tx_immediate", {31'b0, tx}, 32'h1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      load(BASE + 32'h4, 3'b010, rd); check("post_rst_status", rd, 32'h2 | PBIT);
      load(BASE + 32'h8, 3'b010, rd); check("post_rst_baud", rd, 32'h363);
      saw_low = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      check("post_rst_no_frame", {31'b0, saw_low}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
